// File: rtl/dsm2_stereo_if.sv
// PCM sample bus feeding the stereo modulator: one 32-bit MSB-aligned word
// per channel, each with its own one-cycle valid strobe.
interface dsm2_stereo_if;
    logic [31:0] data_l_i;
    logic        data_l_stb_i;
    logic [31:0] data_r_i;
    logic        data_r_stb_i;

    modport master (output data_l_i, data_l_stb_i, data_r_i, data_r_stb_i);
    modport slave  (input  data_l_i, data_l_stb_i, data_r_i, data_r_stb_i);
endinterface

// File: rtl/dsm2_stereo.sv
// Stereo second-order 1-bit delta-sigma modulator with saturating integrators,
// coherent L/R sample hand-over and an IDLE/WAIT/RUN control FSM.
module dsm2_stereo #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 28
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          mod_stb_i,
    dsm2_stereo_if.slave  pcm_if,
    output logic [1:0]    dsm_o,
    output logic          dsm_stb_o,
    output logic [1:0]    ovf_o,
    output logic          run_o
);

    localparam logic signed [ACC_W+1:0] FB_POS  = {{(ACC_W+2-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [ACC_W+1:0] FB_NEG  = -FB_POS;
    localparam logic signed [ACC_W+1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} state_t;

    function automatic logic signed [ACC_W-1:0] sat_f(input logic signed [ACC_W+1:0] v);
        logic signed [ACC_W+1:0] r;
        r = v;
        if (v > SAT_MAX) r = SAT_MAX;
        else if (v < SAT_MIN) r = SAT_MIN;
        return r[ACC_W-1:0];
    endfunction

    function automatic logic clip_f(input logic signed [ACC_W+1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Assertion passes straight through; release is retimed by two flops.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    state_t state_q;
    logic   pair_rdy_q;
    logic   run_q;
    logic   dsm_stb_q;
    logic   copy_w;
    logic   upd_w;
    logic   toggle_w;

    assign copy_w   = en_i && mod_stb_i && pair_rdy_q && (state_q != ST_IDLE);
    assign upd_w    = en_i && mod_stb_i && (state_q == ST_RUN);
    assign toggle_w = mod_stb_i && !(en_i && (state_q == ST_RUN));

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_IDLE;
            pair_rdy_q <= 1'b0;
            run_q      <= 1'b0;
            dsm_stb_q  <= 1'b0;
        end else begin
            dsm_stb_q <= mod_stb_i;
            if (!en_i) begin
                state_q    <= ST_IDLE;
                run_q      <= 1'b0;
                pair_rdy_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_WAIT;
                        run_q   <= 1'b0;
                    end
                    ST_WAIT: begin
                        if (copy_w) begin
                            state_q <= ST_RUN;
                            run_q   <= 1'b1;
                        end
                    end
                    ST_RUN:  run_q <= 1'b1;
                    default: begin
                        state_q <= ST_IDLE;
                        run_q   <= 1'b0;
                    end
                endcase
                // A right sample landing on the copy strobe stays pending for the next one.
                if (pcm_if.data_r_stb_i) pair_rdy_q <= 1'b1;
                else if (copy_w)         pair_rdy_q <= 1'b0;
            end
        end
    end

    assign run_o     = run_q;
    assign dsm_stb_o = dsm_stb_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [IN_W-1:0]         din_w;
            logic                    din_stb_w;
            logic signed [IN_W-1:0]  pend_q;
            logic signed [IN_W-1:0]  x_q;
            logic signed [IN_W-1:0]  x_use_w;
            logic signed [ACC_W-1:0] i1_q;
            logic signed [ACC_W-1:0] i2_q;
            logic signed [ACC_W-1:0] i1_d;
            logic signed [ACC_W-1:0] i2_d;
            logic signed [ACC_W+1:0] fb_w;
            logic signed [ACC_W+1:0] sum1_w;
            logic signed [ACC_W+1:0] sum2_w;
            logic                    clip_w;
            logic                    ovf_q;
            logic                    dsm_q;

            if (gi == 0) begin : g_left
                assign din_w     = pcm_if.data_l_i[31:32-IN_W];
                assign din_stb_w = pcm_if.data_l_stb_i;
            end else begin : g_right
                assign din_w     = pcm_if.data_r_i[31:32-IN_W];
                assign din_stb_w = pcm_if.data_r_stb_i;
            end

            // The copy strobe already integrates the freshly handed-over sample.
            assign x_use_w = copy_w ? pend_q : x_q;
            assign fb_w    = dsm_q ? FB_POS : FB_NEG;
            assign sum1_w  = $signed({{2{i1_q[ACC_W-1]}}, i1_q})
                           + $signed({{(ACC_W+2-IN_W){x_use_w[IN_W-1]}}, x_use_w})
                           - fb_w;
            assign sum2_w  = $signed({{2{i2_q[ACC_W-1]}}, i2_q})
                           + $signed({{2{i1_q[ACC_W-1]}}, i1_q})
                           - fb_w;
            assign i1_d    = sat_f(sum1_w);
            assign i2_d    = sat_f(sum2_w);
            assign clip_w  = clip_f(sum1_w) | clip_f(sum2_w);

            always_ff @(posedge clk_i or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    pend_q <= '0;
                    x_q    <= '0;
                    i1_q   <= '0;
                    i2_q   <= '0;
                    ovf_q  <= 1'b0;
                    dsm_q  <= 1'b0;
                end else begin
                    if (din_stb_w) pend_q <= din_w;
                    if (!en_i) begin
                        x_q   <= '0;
                        i1_q  <= '0;
                        i2_q  <= '0;
                        ovf_q <= 1'b0;
                    end else begin
                        if (copy_w) x_q <= pend_q;
                        if (upd_w) begin
                            i1_q  <= i1_d;
                            i2_q  <= i2_d;
                            ovf_q <= ovf_q | clip_w;
                        end
                    end
                    if (toggle_w)   dsm_q <= ~dsm_q;
                    else if (upd_w) dsm_q <= ~i2_d[ACC_W-1];
                end
            end

            assign dsm_o[gi] = dsm_q;
            assign ovf_o[gi] = ovf_q;
        end
    endgenerate

endmodule

// File: tb/tb_dsm2_stereo.sv
// Randomized bench for dsm2_stereo: an integer-arithmetic reference model is
// compared against the DUT every cycle, plus fixed-scenario literal checks.
module tb_dsm2_stereo;
    localparam int IN_W  = 24;
    localparam int ACC_W = 28;
    localparam longint FBV  = 64'sd1 <<< (IN_W-1);
    localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mod_stb;
    logic [1:0] dsm_o;
    logic       dsm_stb_o;
    logic [1:0] ovf_o;
    logic       run_o;

    dsm2_stereo_if pcm ();

    dsm2_stereo #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .mod_stb_i (mod_stb),
        .pcm_if    (pcm),
        .dsm_o     (dsm_o),
        .dsm_stb_o (dsm_stb_o),
        .ovf_o     (ovf_o),
        .run_o     (run_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ones_l = 0;
    int ones_r = 0;

    // Reference model: mode 0 = disabled/idle, 1 = armed waiting for a pair, 2 = modulating
    int     m_sync;
    int     m_mode;
    bit     m_pair;
    bit     m_stb;
    longint m_pend [2];
    longint m_x    [2];
    longint m_i1   [2];
    longint m_i2   [2];
    bit     m_y    [2];
    bit     m_ovf  [2];

    function automatic longint clamp(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic longint top_bits(input logic [31:0] d);
        return longint'($signed(d)) >>> (32 - IN_W);
    endfunction

    task automatic m_clear();
        m_mode = 0; m_pair = 0; m_stb = 0;
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_x[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0; m_ovf[c] = 0;
        end
    endtask

    task automatic m_step();
        bit     cp;
        longint xv, fb, n1, n2;
        cp    = 0;
        m_stb = mod_stb;
        if (!en) begin
            m_mode = 0; m_pair = 0;
            for (int c = 0; c < 2; c++) begin
                m_x[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_ovf[c] = 0;
                if (mod_stb) m_y[c] = !m_y[c];
            end
        end else begin
            cp = mod_stb && m_pair && (m_mode != 0);
            for (int c = 0; c < 2; c++) begin
                if (mod_stb) begin
                    if (m_mode == 2) begin
                        xv = cp ? m_pend[c] : m_x[c];
                        fb = m_y[c] ? FBV : -FBV;
                        n1 = m_i1[c] + xv - fb;
                        n2 = m_i2[c] + m_i1[c] - fb;
                        if (n1 != clamp(n1) || n2 != clamp(n2)) m_ovf[c] = 1;
                        m_i1[c] = clamp(n1);
                        m_i2[c] = clamp(n2);
                        m_y[c]  = (m_i2[c] >= 0);
                    end else begin
                        m_y[c] = !m_y[c];
                    end
                end
                if (cp) m_x[c] = m_pend[c];
            end
            if (m_mode == 0)              m_mode = 1;
            else if (m_mode == 1 && cp)   m_mode = 2;
            if (pcm.data_r_stb_i) m_pair = 1;
            else if (cp)          m_pair = 0;
        end
        if (pcm.data_l_stb_i) m_pend[0] = top_bits(pcm.data_l_i);
        if (pcm.data_r_stb_i) m_pend[1] = top_bits(pcm.data_r_i);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync = 0;
            m_clear();
        end else if (m_sync < 2) begin
            m_sync = m_sync + 1;
        end else begin
            m_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [1:0] e_dsm, e_ovf;
        logic       e_run;
        e_dsm = {m_y[1], m_y[0]};
        e_ovf = {m_ovf[1], m_ovf[0]};
        e_run = (m_mode == 2);
        total = total + 1;
        if (dsm_o !== e_dsm || dsm_stb_o !== m_stb || ovf_o !== e_ovf || run_o !== e_run) begin
            bad = bad + 1;
            $display("FAIL model t=%0t got dsm=%b stb=%b ovf=%b run=%b expected dsm=%b stb=%b ovf=%b run=%b",
                     $time, dsm_o, dsm_stb_o, ovf_o, run_o, e_dsm, m_stb, e_ovf, e_run);
        end
        if (dsm_stb_o === 1'b1) begin
            ones_l = ones_l + int'(dsm_o[0]);
            ones_r = ones_r + int'(dsm_o[1]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("check %s ok value=%0h", name, got);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        total = total + 1;
        if (got < lo || got > hi) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d expected range %0d..%0d", name, got, lo, hi);
        end else begin
            $display("check %s ok value=%0d", name, got);
        end
    endtask

    task automatic tick(input bit ms, input bit ls, input bit rs, input logic [31:0] ld, input logic [31:0] rd);
        @(negedge clk);
        #1;
        mod_stb = ms;
        pcm.data_l_stb_i = ls;
        pcm.data_r_stb_i = rs;
        pcm.data_l_i = ld;
        pcm.data_r_i = rd;
    endtask

    // One modulator period of 4 clocks; data pair strobed at cycle dpos (none if negative)
    task automatic period(input int dpos, input logic [31:0] ld, input logic [31:0] rd);
        for (int c = 0; c < 4; c++) tick(c == 0, c == dpos, c == dpos, ld, rd);
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        #1;
        en = v;
    endtask

    task automatic held(input int n, input logic [31:0] ld, input logic [31:0] rd);
        for (int p = 0; p < n; p++) period((p % 4 == 0) ? int'($urandom_range(1, 3)) : -1, ld, rd);
    endtask

    initial begin
        logic [1:0] prev;
        rst_n = 1'b0; en = 1'b0; mod_stb = 1'b0;
        pcm.data_l_i = '0; pcm.data_r_i = '0; pcm.data_l_stb_i = 1'b0; pcm.data_r_stb_i = 1'b0;
        repeat (3) tick(0, 0, 0, 0, 0);
        check("reset_outputs", {27'd0, dsm_o, dsm_stb_o, ovf_o, run_o}, 32'd0);
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (4) tick(0, 0, 0, 0, 0);

        // Disabled: toggling zero-level pattern starting at 11
        for (int k = 0; k < 8; k++) begin
            tick(1, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0);
            check("idle_toggle", {29'd0, run_o, dsm_o}, (k % 2 == 0) ? 32'd3 : 32'd0);
            tick(0, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0);
        end

        // Zero input: run starts on the copy, density near one half
        set_en(1);
        repeat (2) tick(0, 0, 0, 0, 0);
        period(1, 32'h0, 32'h0);
        check("run_before_copy", {31'd0, run_o}, 32'd0);
        period(-1, 32'h0, 32'h0);
        check("run_after_copy", {31'd0, run_o}, 32'd1);
        ones_l = 0; ones_r = 0;
        held(1024, 32'h0, 32'h0);
        check_rng("zero_ones_l", ones_l, 510, 514);
        check_rng("zero_ones_r", ones_r, 510, 514);
        check("zero_ovf", {30'd0, ovf_o}, 32'd0);

        // Half-scale positive left, negative right
        held(32, 32'h4000_0000, 32'hC000_0000);
        ones_l = 0; ones_r = 0;
        held(4096, 32'h4000_0000, 32'hC000_0000);
        check_rng("half_ones_l", ones_l, 3031, 3113);
        check_rng("half_ones_r", ones_r, 993, 1075);
        check("half_ovf", {30'd0, ovf_o}, 32'd0);

        // Full-scale left drives the integrators into saturation
        set_en(0);
        set_en(1);
        held(128, 32'h7FFF_FFFF, 32'h0);
        check("fs_ovf_early", {30'd0, ovf_o}, 32'd1);
        held(1024, 32'h7FFF_FFFF, 32'h0);
        check("fs_ovf_sticky", {30'd0, ovf_o}, 32'd1);

        // Dropping enable mid-run
        set_en(0);
        tick(0, 0, 0, 32'h7FFF_FFFF, 0);
        check("dis_run_ovf", {29'd0, run_o, ovf_o}, 32'd0);
        prev = dsm_o;
        period(-1, 32'h7FFF_FFFF, 0);
        check("dis_toggle", {30'd0, dsm_o}, {30'd0, ~prev});
        set_en(1);
        repeat (3) period(-1, 32'h7FFF_FFFF, 0);
        check("reen_waits", {31'd0, run_o}, 32'd0);
        period(2, 32'h1000_0000, 32'hF000_0000);
        period(-1, 32'h1000_0000, 32'hF000_0000);
        check("reen_runs", {31'd0, run_o}, 32'd1);

        // Right strobe coincident with the modulator strobe defers the copy
        set_en(0);
        set_en(1);
        repeat (2) tick(0, 0, 0, 0, 0);
        period(0, 32'h2000_0000, 32'h2000_0000);
        check("coinc_no_copy", {31'd0, run_o}, 32'd0);
        period(-1, 32'h2000_0000, 32'h2000_0000);
        check("coinc_copy_next", {31'd0, run_o}, 32'd1);
        held(16, 32'h2000_0000, 32'h2000_0000);

        // Asynchronous reset mid-run acts before any clock edge
        @(negedge clk); #2; rst_n = 1'b0;
        #1;
        check("async_reset", {28'd0, dsm_o, ovf_o, run_o}, 32'd0);
        repeat (3) tick(0, 0, 0, 0, 0);
        @(negedge clk); #1; rst_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk); #1;
            en      = ($urandom_range(0, 299) != 0);
            mod_stb = ($urandom_range(0, 3) == 0);
            pcm.data_l_stb_i = ($urandom_range(0, 7) == 0);
            pcm.data_r_stb_i = ($urandom_range(0, 7) == 0);
            pcm.data_l_i = $urandom;
            pcm.data_r_i = $urandom;
            if (n == 2000) rst_n = 1'b0;
            if (n == 2003) rst_n = 1'b1;
        end
        repeat (4) tick(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
